// File: rtl/pong_if.sv
// Handshake bundle between the Pong match sequencer (slave) and its user (master).
// PONG_PAUSE_EN adds the level-sensitive pause input.
interface pong_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               p1_miss;
  logic               p2_miss;
`ifdef PONG_PAUSE_EN
  logic               pause;
`endif
  logic               step_en;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [2:0]         state;
  logic               game_over;
  logic [1:0]         winner;

`ifdef PONG_PAUSE_EN
  modport master (
    output start, p1_miss, p2_miss, pause,
    input  step_en, ball_reset, serve_dir, p1_score, p2_score, state, game_over, winner
  );
  modport slave (
    input  start, p1_miss, p2_miss, pause,
    output step_en, ball_reset, serve_dir, p1_score, p2_score, state, game_over, winner
  );
`else
  modport master (
    output start, p1_miss, p2_miss,
    input  step_en, ball_reset, serve_dir, p1_score, p2_score, state, game_over, winner
  );
  modport slave (
    input  start, p1_miss, p2_miss,
    output step_en, ball_reset, serve_dir, p1_score, p2_score, state, game_over, winner
  );
`endif
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: ball-step tick divider, serve/play/point/over FSM, scores and winner.
// Optional feature macro PONG_PAUSE_EN adds a pause input that freezes ticks and the FSM.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 125000,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4
) (
  input  logic  clk,
  input  logic  reset,
  pong_if.slave bus
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SRV_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic               serve_dir_q, serve_dir_d;
  logic [1:0]         winner_q, winner_d;
  logic               step_en_q, step_en_d;
  logic               ball_reset_q, ball_reset_d;
  logic               game_over_q, game_over_d;
  logic               pause_s;
  logic               tick_s;

`ifdef PONG_PAUSE_EN
  assign pause_s = bus.pause;
`else
  assign pause_s = 1'b0;
`endif

  // A frozen divider never produces a tick, so pause also stalls SERVE and step_en.
  assign tick_s = !pause_s && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (pause_s) begin
      tick_cnt_d = tick_cnt_q;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p1_score_d  = '0;
          p2_score_d  = '0;
          serve_cnt_d = '0;
          serve_dir_d = 1'b1;
          winner_d    = 2'b00;
          state_d     = S_SERVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SERVE: begin
        if (tick_s) begin
          if (serve_cnt_q == SRV_W'(SERVE_DELAY - 1)) begin
            serve_cnt_d = '0;
            state_d     = S_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SRV_W'(1);
          end
        end else begin
          serve_cnt_d = serve_cnt_q;
        end
      end
      S_PLAY: begin
        // The point goes to the opponent of whoever missed; the next serve heads toward the loser.
        if (pause_s) begin
          state_d = S_PLAY;
        end else if (bus.p1_miss && bus.p2_miss) begin
          serve_dir_d = !serve_dir_q;
          state_d     = S_SERVE;
        end else if (bus.p2_miss) begin
          if (p1_score_q < SCORE_W'(WIN_SCORE)) begin
            p1_score_d = p1_score_q + SCORE_W'(1);
          end else begin
            p1_score_d = p1_score_q;
          end
          serve_dir_d = 1'b1;
          state_d     = S_POINT;
        end else if (bus.p1_miss) begin
          if (p2_score_q < SCORE_W'(WIN_SCORE)) begin
            p2_score_d = p2_score_q + SCORE_W'(1);
          end else begin
            p2_score_d = p2_score_q;
          end
          serve_dir_d = 1'b0;
          state_d     = S_POINT;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_POINT: begin
        if (pause_s) begin
          state_d = S_POINT;
        end else if (p1_score_q == SCORE_W'(WIN_SCORE)) begin
          winner_d = 2'b01;
          state_d  = S_OVER;
        end else if (p2_score_q == SCORE_W'(WIN_SCORE)) begin
          winner_d = 2'b10;
          state_d  = S_OVER;
        end else begin
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          p1_score_d  = '0;
          p2_score_d  = '0;
          serve_cnt_d = '0;
          winner_d    = 2'b00;
          state_d     = S_SERVE;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they line up with state once registered.
  always_comb begin
    step_en_d    = (state_q == S_PLAY) && (state_d == S_PLAY) && tick_s;
    ball_reset_d = (state_d != S_PLAY);
    game_over_d  = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      serve_cnt_q  <= '0;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      serve_dir_q  <= 1'b1;
      winner_q     <= 2'b00;
      step_en_q    <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      serve_cnt_q  <= serve_cnt_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      step_en_q    <= step_en_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.step_en    = step_en_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.p1_score   = p1_score_q;
  assign bus.p2_score   = p2_score_q;
  assign bus.state      = state_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
endmodule
